effect_output_buffer: RTL
=========================

// Module: effect_output_buffer
// PURPOSE
//  Consumer end of the effect chain's sample/done handshake. Accepts 12-bit signed samples
//  strobed by `done` at 24 kHz and buffers them in a small FIFO. Each sample is upsampled
//  2x by linear interpolation and delivered to the codec path on its 48 kHz `codec_ready`
//  strobe. Sits between the last effect stage and the AC97 interface.
// PARAMETERS
//  LOG_DEPTH  4   FIFO address width; depth = 2**LOG_DEPTH samples (16)
//  IN_WIDTH   12  input sample width, signed
//  OUT_WIDTH  8   codec sample width, signed; must be <= IN_WIDTH
// PORTS
//  clock        in   1            system clock, single clock domain
//  reset_n      in   1            asynchronous, active-low reset
//  done         in   1            one-cycle strobe: sample_in is valid this cycle
//  sample_in    in   IN_WIDTH     signed sample from effect stage
//  codec_ready  in   1            one-cycle strobe from codec: deliver next output sample
//  clear_flags  in   1            synchronous clear of overflow/underflow
//  to_codec     out  OUT_WIDTH    signed output sample, held between updates
//  out_valid    out  1            one-cycle strobe: to_codec updated this cycle
//  level        out  LOG_DEPTH+1  current FIFO occupancy, 0..2**LOG_DEPTH
//  overflow     out  1            sticky: a sample was dropped because the FIFO was full
//  underflow    out  1            sticky: a pop was needed while the FIFO was empty
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs 0; rd/wr pointers, level, prev, cur, phase = 0;
//   output FSM -> IDLE. Applies mid-operation: buffered samples are discarded.
//  Write: done=1 and (level<DEPTH or a pop occurs in this same cycle) -> store sample_in
//   at wr_ptr, wr_ptr+1 (wraps mod DEPTH). done=1 and full with no pop -> drop sample,
//   overflow<=1.
//  Level: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop.
//  Output FSM (states IDLE, FETCH, EMIT); `phase` toggles on every accepted codec_ready.
//   IDLE: on codec_ready:
//    - phase=0 and level>0: pop (rd_ptr+1), go to FETCH.
//    - phase=0 and level=0: underflow<=1, no pop, cur is repeated, go to EMIT.
//    - phase=1: go to EMIT.
//   FETCH (1 cycle, registered memory read): prev<=cur, cur<=mem_out, go to EMIT.
//   EMIT: phase=0 (just popped/underflowed): to_codec <= trunc((prev+cur)>>>1);
//    phase=1: to_codec <= trunc(cur). out_valid=1 for 1 cycle; toggle phase; go to IDLE.
//  Latency: codec_ready at cycle t -> out_valid/to_codec at t+2 (pop) or t+1 (no pop).
//  codec_ready arriving while not in IDLE is ignored; the codec spaces strobes >= 3 cycles.
//  Arithmetic: prev+cur is sign-extended to IN_WIDTH+1 bits, then arithmetic shift right
//   by 1; no overflow is possible. trunc() keeps bits [IN_WIDTH-1 : IN_WIDTH-OUT_WIDTH];
//   the discarded LSBs are truncated, not rounded.
//  Flags: overflow/underflow are sticky until clear_flags=1. If clear_flags and a new
//   event occur in the same cycle, the event wins (flag stays 1).
//  done ignores output FSM state; writes and pops are independent and happen in parallel.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE=2'b00, FETCH=2'b01, EMIT=2'b10)
//   and the default audio widths (IN_WIDTH=12, OUT_WIDTH=8).
//  Sub-module: sample_fifo (existing mybram instance, LOGSIZE=LOG_DEPTH, WIDTH=IN_WIDTH,
//   plus pointers, level, and full/empty logic). Top level holds the output FSM,
//   interpolator and flags.
// TESTING
//  1 Reset: drive reset_n=0 mid-stream with level=5 -> level=0, to_codec=0, flags=0,
//    and the next codec_ready yields underflow=1.
//  2 Interpolation: push 12'sd400, then 12'sd800; issue 4 codec_ready strobes ->
//    to_codec = trunc(200)=12, trunc(400)=25, trunc(600)=37, trunc(800)=50;
//    out_valid exactly 2 cycles after each popping strobe.
//  3 Negative values: push 12'sh800 (-2048) after cur=0 -> midpoint -1024 -> to_codec=-64;
//    next output -128.
//  4 Overflow: push 17 samples with no codec_ready -> level=16, overflow=1, 17th dropped;
//    clear_flags -> overflow=0.
//  5 Simultaneous push+pop at full: done in the same cycle as a FETCH pop -> sample
//    accepted, level stays 16, overflow remains 0.
//  6 Underflow: codec_ready on phase 0 with empty FIFO -> underflow=1, to_codec equals
//    the midpoint of the previous cur with itself; level stays 0; rd_ptr does not change.

Source files
------------

// File: rtl/effect_output_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : effect_output_buffer_pkg
//  Purpose  : Shared definitions for the effect output buffer: output FSM
//             state encoding and the default audio/FIFO widths.
//  Revision : 1.0  initial release
// ============================================================================
package effect_output_buffer_pkg;

    // Output FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EMIT  = 2'b10
    } out_state_e;

    // Default audio widths and FIFO depth
    localparam int DEFAULT_LOG_DEPTH = 4;
    localparam int DEFAULT_IN_WIDTH  = 12;
    localparam int DEFAULT_OUT_WIDTH = 8;

endpackage : effect_output_buffer_pkg
`default_nettype wire

// File: rtl/effect_output_buffer_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mybram / sample_fifo
//  Purpose  : mybram is a simple dual-port block RAM with a registered,
//             read-first read port. sample_fifo wraps it with write/read
//             pointers, an occupancy counter and full/empty detection.
//  Revision : 1.0  initial release
// ============================================================================
module mybram #(
    parameter int LOGSIZE = 4,
    parameter int WIDTH   = 12
) (
    input  logic               clk,
    input  logic               we,
    input  logic [LOGSIZE-1:0] addr_w,
    input  logic [WIDTH-1:0]   din,
    input  logic [LOGSIZE-1:0] addr_r,
    output logic [WIDTH-1:0]   dout
);
    logic [WIDTH-1:0] mem [2**LOGSIZE];

    // Storage write and registered read; a same-address read returns old data
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr_w] <= din;
        end
        dout <= mem[addr_r];
    end
endmodule : mybram

module sample_fifo #(
    parameter int LOG_DEPTH = 4,
    parameter int WIDTH     = 12
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wr_req,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rd_data,
    output logic [LOG_DEPTH:0]   level,
    output logic                 empty,
    output logic                 dropped
);
    localparam int DEPTH = 2 ** LOG_DEPTH;

    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   level_q, level_d;
    logic                 w_full;
    logic                 w_wr_en;

    // A full FIFO can still accept a sample when a pop frees a slot this cycle
    always_comb begin
        w_full   = (level_q == (LOG_DEPTH+1)'(DEPTH));
        empty    = (level_q == '0);
        w_wr_en  = wr_req & (~w_full | pop);
        dropped  = wr_req & w_full & ~pop;
        wr_ptr_d = w_wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (w_wr_en && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !w_wr_en) begin
            level_d = level_q - 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign level = level_q;

    // The read port always tracks rd_ptr, so the popped word appears the
    // cycle after the pop
    mybram #(
        .LOGSIZE (LOG_DEPTH),
        .WIDTH   (WIDTH)
    ) u_mybram (
        .clk    (clock),
        .we     (w_wr_en),
        .addr_w (wr_ptr_q),
        .din    (wr_data),
        .addr_r (rd_ptr_q),
        .dout   (rd_data)
    );
endmodule : sample_fifo
`default_nettype wire

// File: rtl/effect_output_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : effect_output_buffer
//  Purpose  : Buffers 24 kHz effect samples and delivers them 2x upsampled
//             by linear interpolation on the 48 kHz codec strobe.
//             OUT_WIDTH must not exceed IN_WIDTH.
//  Revision : 1.0  initial release
// ============================================================================
module effect_output_buffer
    import effect_output_buffer_pkg::*;
#(
    parameter int LOG_DEPTH = DEFAULT_LOG_DEPTH,
    parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
    parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        done,
    input  logic signed [IN_WIDTH-1:0]  sample_in,
    input  logic                        codec_ready,
    input  logic                        clear_flags,
    output logic signed [OUT_WIDTH-1:0] to_codec,
    output logic                        out_valid,
    output logic [LOG_DEPTH:0]          level,
    output logic                        overflow,
    output logic                        underflow
);

    out_state_e                  state_q, state_d;
    logic                        phase_q, phase_d;
    logic signed [IN_WIDTH-1:0]  prev_q, prev_d;
    logic signed [IN_WIDTH-1:0]  cur_q, cur_d;
    logic signed [OUT_WIDTH-1:0] to_codec_q, to_codec_d;
    logic                        out_valid_q, out_valid_d;
    logic                        overflow_q, overflow_d;
    logic                        underflow_q, underflow_d;

    logic                        w_pop;
    logic                        w_underflow_evt;
    logic                        w_fifo_empty;
    logic                        w_dropped;
    logic [IN_WIDTH-1:0]         w_mem_out;

    // Keep the top OUT_WIDTH bits of a sample (truncating the LSBs)
    function automatic logic signed [OUT_WIDTH-1:0] trunc_sample(
        input logic signed [IN_WIDTH-1:0] s
    );
        return OUT_WIDTH'(s >>> (IN_WIDTH - OUT_WIDTH));
    endfunction

    // Midpoint of two samples; one guard bit makes the sum overflow-free
    function automatic logic signed [OUT_WIDTH-1:0] interp(
        input logic signed [IN_WIDTH-1:0] a,
        input logic signed [IN_WIDTH-1:0] b
    );
        logic signed [IN_WIDTH:0]   sum;
        logic signed [IN_WIDTH-1:0] mid;
        sum = $signed({a[IN_WIDTH-1], a}) + $signed({b[IN_WIDTH-1], b});
        mid = IN_WIDTH'(sum >>> 1);
        return trunc_sample(mid);
    endfunction

    sample_fifo #(
        .LOG_DEPTH (LOG_DEPTH),
        .WIDTH     (IN_WIDTH)
    ) u_sample_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_req  (done),
        .wr_data (sample_in),
        .pop     (w_pop),
        .rd_data (w_mem_out),
        .level   (level),
        .empty   (w_fifo_empty),
        .dropped (w_dropped)
    );

    // Output FSM next state: outputs are loaded on entry to EMIT so that
    // out_valid is high for exactly the EMIT cycle
    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        prev_d          = prev_q;
        cur_d           = cur_q;
        to_codec_d      = to_codec_q;
        out_valid_d     = 1'b0;
        w_pop           = 1'b0;
        w_underflow_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (codec_ready) begin
                    if (!phase_q) begin
                        if (!w_fifo_empty) begin
                            w_pop   = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            // Starved: repeat the current sample
                            w_underflow_evt = 1'b1;
                            prev_d          = cur_q;
                            to_codec_d      = interp(cur_q, cur_q);
                            out_valid_d     = 1'b1;
                            state_d         = ST_EMIT;
                        end
                    end else begin
                        to_codec_d  = trunc_sample(cur_q);
                        out_valid_d = 1'b1;
                        state_d     = ST_EMIT;
                    end
                end
            end
            ST_FETCH: begin
                prev_d      = cur_q;
                cur_d       = $signed(w_mem_out);
                to_codec_d  = interp(cur_q, $signed(w_mem_out));
                out_valid_d = 1'b1;
                state_d     = ST_EMIT;
            end
            ST_EMIT: begin
                phase_d = ~phase_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags: a new event in the clearing cycle keeps the flag set
    always_comb begin
        overflow_d  = (overflow_q  & ~clear_flags) | w_dropped;
        underflow_d = (underflow_q & ~clear_flags) | w_underflow_evt;
    end

    // FSM, interpolator history and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            prev_q      <= '0;
            cur_q       <= '0;
            to_codec_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            to_codec_q  <= to_codec_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign to_codec  = to_codec_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : effect_output_buffer
`default_nettype wire
